// File: rtl/ym2149_bus_master.sv
// rtl/ym2149_bus_master.sv - queued register-access bus master for the YM2149 PSG
// Requests are replayed as setup/strobe bus phases; a repeated address skips the latch phases.
module ym2149_bus_master #(
  parameter int PHASE_LEN  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_WR,
  input  logic [3:0] REQ_ADDR,
  input  logic [7:0] REQ_DATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       BUSY,
  output logic       BDIR,
  output logic       BC,
  output logic       A8,
  output logic [7:0] DO,
  input  logic [7:0] DI
);
  localparam int          PW         = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  PHASE_LAST = 4'(PHASE_LEN - 1);
  localparam logic [PW:0] FULL_CNT   = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, ADDR_SETUP, ADDR_STROBE, DATA_SETUP, DATA_STROBE, READ_WAIT, GAP
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    phase_q, phase_d;
  logic [12:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          ready_q, ready_d, busy_q, busy_d;
  logic          cur_wr_q, cur_wr_d;
  logic [3:0]    cur_addr_q, cur_addr_d;
  logic [7:0]    cur_data_q, cur_data_d;
  logic          cache_valid_q, cache_valid_d;
  logic [3:0]    cache_addr_q, cache_addr_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          bdir_q, bdir_d, bc_q, bc_d, a8_q, a8_d;
  logic [7:0]    do_q, do_d;
  logic          push, pop, phase_done;
  logic [12:0]   head;

  // Readiness is the registered not-full flag, so a pop never frees a slot in its own cycle.
  assign push       = REQ_VALID && ready_q;
  assign pop        = (state_q == IDLE) && (count_q != '0);
  assign head       = fifo_mem[rd_ptr_q];
  assign phase_done = (phase_q == PHASE_LAST);

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_q] <= {REQ_WR, REQ_ADDR, REQ_DATA};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != FULL_CNT);
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    cur_wr_d      = cur_wr_q;
    cur_addr_d    = cur_addr_q;
    cur_data_d    = cur_data_q;
    cache_valid_d = cache_valid_q;
    cache_addr_d  = cache_addr_q;
    rsp_data_d    = rsp_data_q;
    rsp_valid_d   = 1'b0;
    if (state_q inside {ADDR_SETUP, ADDR_STROBE, DATA_SETUP, DATA_STROBE, READ_WAIT})
      phase_d = phase_done ? 4'd0 : phase_q + 4'd1;
    case (state_q)
      IDLE: begin
        phase_d = 4'd0;
        if (pop) begin
          {cur_wr_d, cur_addr_d, cur_data_d} = head;
          if (!cache_valid_q || cache_addr_q != head[11:8]) state_d = ADDR_SETUP;
          else state_d = head[12] ? DATA_SETUP : READ_WAIT;
        end
      end
      ADDR_SETUP:  if (phase_done) state_d = ADDR_STROBE;
      ADDR_STROBE: if (phase_done) begin
        cache_valid_d = 1'b1;
        cache_addr_d  = cur_addr_q;
        state_d       = cur_wr_q ? DATA_SETUP : READ_WAIT;
      end
      DATA_SETUP:  if (phase_done) state_d = DATA_STROBE;
      DATA_STROBE: if (phase_done) state_d = GAP;
      READ_WAIT:   if (phase_done) begin
        rsp_data_d  = DI;
        rsp_valid_d = 1'b1;
        state_d     = GAP;
      end
      default:     state_d = IDLE;
    endcase
  end

  // Bus pins are decoded from the next state so they are registered yet aligned with it.
  always_comb begin
    bdir_d = 1'b0;
    bc_d   = 1'b0;
    do_d   = 8'h00;
    a8_d   = (state_d != IDLE);
    busy_d = (state_d != IDLE) || (count_d != '0);
    case (state_d)
      ADDR_SETUP:  begin bc_d = 1'b1; do_d = {4'b0, cur_addr_d}; end
      ADDR_STROBE: begin bdir_d = 1'b1; bc_d = 1'b1; do_d = {4'b0, cur_addr_d}; end
      DATA_SETUP:  do_d = cur_data_d;
      DATA_STROBE: begin bdir_d = 1'b1; do_d = cur_data_d; end
      READ_WAIT:   bc_d = 1'b1;
      default:     do_d = 8'h00;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      phase_q       <= 4'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ready_q       <= 1'b0;
      busy_q        <= 1'b0;
      cur_wr_q      <= 1'b0;
      cur_addr_q    <= 4'd0;
      cur_data_q    <= 8'h00;
      cache_valid_q <= 1'b0;
      cache_addr_q  <= 4'd0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 8'h00;
      bdir_q        <= 1'b0;
      bc_q          <= 1'b0;
      a8_q          <= 1'b0;
      do_q          <= 8'h00;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      cur_wr_q      <= cur_wr_d;
      cur_addr_q    <= cur_addr_d;
      cur_data_q    <= cur_data_d;
      cache_valid_q <= cache_valid_d;
      cache_addr_q  <= cache_addr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      bdir_q        <= bdir_d;
      bc_q          <= bc_d;
      a8_q          <= a8_d;
      do_q          <= do_d;
    end
  end

  assign REQ_READY = ready_q;
  assign BUSY      = busy_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign BDIR      = bdir_q;
  assign BC        = bc_q;
  assign A8        = a8_q;
  assign DO        = do_q;
endmodule

// File: tb/tb_ym2149_bus_master.sv
// tb/tb_ym2149_bus_master.sv - self-checking bench for ym2149_bus_master
// A PSG bus model and a transaction-level reference predict bus timing, register contents and read data.
module tb_ym2149_bus_master;
  localparam int P0 = 2;
  localparam int P1 = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0, req_wr = 1'b0;
  logic [3:0] req_addr = 4'd0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, rsp_valid, busy, bdir, bc, a8;
  logic [7:0] rsp_data, dout, psg_di;

  logic       req_valid1 = 1'b0, req_wr1 = 1'b0;
  logic [3:0] req_addr1 = 4'd0;
  logic [7:0] req_data1 = 8'h00, di1 = 8'h00;
  logic       req_ready1, rsp_valid1, busy1, bdir1, bc1, a81;
  logic [7:0] rsp_data1, dout1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ym2149_bus_master #(.PHASE_LEN(P0), .FIFO_DEPTH(4)) dut (
    .CLK(clk), .RESET_N(rst_n), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_WR(req_wr), .REQ_ADDR(req_addr), .REQ_DATA(req_data),
    .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data), .BUSY(busy),
    .BDIR(bdir), .BC(bc), .A8(a8), .DO(dout), .DI(psg_di));

  ym2149_bus_master #(.PHASE_LEN(P1), .FIFO_DEPTH(4)) dut1 (
    .CLK(clk), .RESET_N(rst_n), .REQ_VALID(req_valid1), .REQ_READY(req_ready1),
    .REQ_WR(req_wr1), .REQ_ADDR(req_addr1), .REQ_DATA(req_data1),
    .RSP_VALID(rsp_valid1), .RSP_DATA(rsp_data1), .BUSY(busy1),
    .BDIR(bdir1), .BC(bc1), .A8(a81), .DO(dout1), .DI(di1));

  function automatic logic [7:0] reg_mask(input logic [3:0] a);
    case (a)
      4'd1, 4'd3, 4'd5, 4'd13: return 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: return 8'h1F;
      default:                 return 8'hFF;
    endcase
  endfunction

  // PSG model on the primary DUT's bus, plus per-transaction logs.
  logic [7:0]  psg_regs [16] = '{default: 8'h00};
  logic [3:0]  psg_latch = 4'd0;
  logic [9:0]  trace[$];
  logic [11:0] wr_log[$];
  logic [7:0]  rsp_log[$];
  int          len_log[$];
  int          rise_log[$];
  int          cur_len = 0, cur_rises = 0, total_rises = 0, rsp_run = 0, rsp_bad = 0;
  bit          bdir_prev = 0, a8_prev = 0, rsp_prev = 0;

  assign psg_di = psg_regs[psg_latch];

  always @(negedge clk) begin
    if (a8) begin
      trace.push_back({bdir, bc, dout});
      cur_len++;
      if (bdir && !bdir_prev) cur_rises++;
    end else if (a8_prev) begin
      len_log.push_back(cur_len);
      rise_log.push_back(cur_rises);
      cur_len = 0;
      cur_rises = 0;
    end
    if (bdir && !bdir_prev) begin
      total_rises++;
      if (bc) psg_latch = dout[3:0];
      else begin
        psg_regs[psg_latch] = dout & reg_mask(psg_latch);
        wr_log.push_back({psg_latch, dout});
      end
    end
    if (rsp_valid) begin
      if (!rsp_prev) rsp_log.push_back(rsp_data);
      rsp_run++;
    end else begin
      if (rsp_prev && rsp_run != 1) rsp_bad++;
      rsp_run = 0;
    end
    bdir_prev = bdir;
    a8_prev   = a8;
    rsp_prev  = rsp_valid;
  end

  // Transaction-level reference: cycle cost from cache hit/miss, and shadow register file.
  logic [7:0] shadow [16] = '{default: 8'h00};
  bit         m_cache_v = 0;
  logic [3:0] m_cache_a = 4'd0;

  task automatic model_exec(input bit wr, input logic [3:0] a, input logic [7:0] d,
                            output int len, output logic [7:0] rv, output int rises);
    bit miss;
    miss  = !m_cache_v || (m_cache_a != a);
    len   = (miss ? 2 * P0 : 0) + (wr ? 2 * P0 : P0) + 1;
    rises = (miss ? 1 : 0) + (wr ? 1 : 0);
    if (wr) shadow[a] = d & reg_mask(a);
    rv = shadow[a];
    m_cache_v = 1;
    m_cache_a = a;
  endtask

  task automatic push0(input bit wr, input logic [3:0] a, input logic [7:0] d, output bit ok);
    int n = 0;
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_data = d;
    while (!req_ready && n < 500) begin @(posedge clk); #1; n++; end
    ok = req_ready;
    if (ok) begin @(posedge clk); #1; end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle0(output bit ok);
    int n = 0;
    while ((busy || a8) && n < 3000) begin @(posedge clk); #1; n++; end
    ok = !busy && !a8;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    m_cache_v = 0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({req_ready, busy, bdir, bc, a8, dout, rsp_valid, rsp_data} !== 22'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%h want=0", {req_ready, busy, bdir, bc, a8, dout, rsp_valid, rsp_data});
    end
    tests_run++;
    if ({req_ready1, busy1, bdir1, bc1, a81, dout1} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs_p1 got=%h want=0", {req_ready1, busy1, bdir1, bc1, a81, dout1});
    end
    rst_n = 1'b1;
    tests_run++;
    if (req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL ready_before_edge got=%b want=0", req_ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (req_ready !== 1'b1 || req_ready1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL ready_after_edge got=%b%b want=11", req_ready, req_ready1);
    end
  endtask

  task automatic test_reg7_write();
    int bl = len_log.size(), bt = trace.size(), br = rsp_log.size();
    int len, rises, bad = 0;
    logic [7:0] rv;
    logic [9:0] exp[$];
    bit ok, ok2;
    model_exec(1'b1, 4'd7, 8'h38, len, rv, rises);
    for (int i = 0; i < P0; i++) exp.push_back({2'b01, 8'h07});
    for (int i = 0; i < P0; i++) exp.push_back({2'b11, 8'h07});
    for (int i = 0; i < P0; i++) exp.push_back({2'b00, 8'h38});
    for (int i = 0; i < P0; i++) exp.push_back({2'b10, 8'h38});
    exp.push_back({2'b00, 8'h00});
    push0(1'b1, 4'd7, 8'h38, ok);
    wait_idle0(ok2);
    tests_run++;
    if (!ok || !ok2 || len_log.size() != bl + 1 || len_log[bl] != 9 || len !== 9) begin
      tests_failed++;
      $display("FAIL reg7_len got=%0d want=9 (ok=%b%b)", (len_log.size() > bl) ? len_log[bl] : -1, ok, ok2);
    end
    if (trace.size() != bt + exp.size()) bad++;
    else for (int i = 0; i < exp.size(); i++) if (trace[bt + i] !== exp[i]) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL reg7_phase_trace got=%0d bad cycles want=0", bad);
    end
    tests_run++;
    if (psg_regs[7] !== 8'h38) begin
      tests_failed++;
      $display("FAIL reg7_psg got=%h want=38", psg_regs[7]);
    end
    tests_run++;
    if (rsp_log.size() != br) begin
      tests_failed++;
      $display("FAIL reg7_no_rsp got=%0d pulses want=0", rsp_log.size() - br);
    end
  endtask

  task automatic test_cached_write();
    int bl = len_log.size(), l1, l2, r1, r2, rb;
    logic [7:0] rv;
    bit ok1, ok2, ok3;
    model_exec(1'b1, 4'd8, 8'h0F, l1, rv, r1);
    model_exec(1'b1, 4'd8, 8'h10, l2, rv, r2);
    push0(1'b1, 4'd8, 8'h0F, ok1);
    wait_idle0(ok3);
    rb = total_rises;
    push0(1'b1, 4'd8, 8'h10, ok2);
    wait_idle0(ok3);
    tests_run++;
    if (len_log.size() != bl + 2 || len_log[bl] != l1 || len_log[bl + 1] != 5 || l2 != 5 || !ok1 || !ok2) begin
      tests_failed++;
      $display("FAIL cached_len got=%0d want=%0d,5", len_log.size() - bl, l1);
    end
    tests_run++;
    if (total_rises - rb != 1 || rise_log[bl + 1] != r2) begin
      tests_failed++;
      $display("FAIL cached_rises got=%0d want=1", total_rises - rb);
    end
    tests_run++;
    if (psg_regs[8] !== shadow[8] || shadow[8] !== 8'h10) begin
      tests_failed++;
      $display("FAIL cached_psg got=%h want=10", psg_regs[8]);
    end
  endtask

  task automatic test_read();
    int bl = len_log.size(), br = rsp_log.size(), bb = rsp_bad, l1, l2, r;
    logic [7:0] rv;
    bit ok1, ok2, ok3;
    model_exec(1'b1, 4'd1, 8'hA5, l1, rv, r);
    model_exec(1'b0, 4'd1, 8'h00, l2, rv, r);
    push0(1'b1, 4'd1, 8'hA5, ok1);
    push0(1'b0, 4'd1, 8'h5A, ok2);
    wait_idle0(ok3);
    tests_run++;
    if (rsp_log.size() != br + 1 || rsp_log[br] !== 8'h05 || rv !== 8'h05 || !ok1 || !ok2) begin
      tests_failed++;
      $display("FAIL read_data got=%h (%0d pulses) want=05", (rsp_log.size() > br) ? rsp_log[br] : 8'hxx, rsp_log.size() - br);
    end
    tests_run++;
    if (rsp_bad != bb) begin
      tests_failed++;
      $display("FAIL read_pulse_width got=%0d bad want=0", rsp_bad - bb);
    end
    tests_run++;
    if (len_log.size() != bl + 2 || len_log[bl] != l1 || len_log[bl + 1] != l2 || l2 != P0 + 1) begin
      tests_failed++;
      $display("FAIL read_len got=%0d entries want=%0d,%0d", len_log.size() - bl, l1, l2);
    end
    tests_run++;
    if (rsp_data !== 8'h05 || rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_hold got=%h/%b want=05/0", rsp_data, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int bw = wr_log.size(), bl = len_log.size(), len, r, n = 0, bad = 0;
    logic [7:0] rv, d;
    logic [3:0] a;
    logic [11:0] exp_wr[$];
    int exp_len[$];
    bit ok, okall = 1, prev;
    d = 8'($urandom);
    model_exec(1'b1, 4'd0, d, len, rv, r);
    exp_len.push_back(len); exp_wr.push_back({4'd0, d});
    push0(1'b1, 4'd0, d, ok); okall &= ok;
    for (int k = 0; k < 5; k++) begin
      a = 4'(k + 2);
      d = 8'($urandom);
      model_exec(1'b1, a, d, len, rv, r);
      exp_len.push_back(len); exp_wr.push_back({a, d});
      push0(1'b1, a, d, ok); okall &= ok;
      if (k == 3) begin
        tests_run++;
        if (req_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_full got=%b want=0", req_ready);
        end
        do begin prev = a8; @(posedge clk); #1; n++; end while (!req_ready && n < 100);
        tests_run++;
        if (!(req_ready === 1'b1 && a8 === 1'b1 && prev === 1'b0)) begin
          tests_failed++;
          $display("FAIL b2b_ready_on_pop got=rdy%b a8 %b->%b want=rdy1 a8 0->1", req_ready, prev, a8);
        end
      end
    end
    wait_idle0(ok); okall &= ok;
    if (wr_log.size() != bw + 6 || len_log.size() != bl + 6) bad++;
    else for (int i = 0; i < 6; i++) if (wr_log[bw + i] !== exp_wr[i] || len_log[bl + i] != exp_len[i]) bad++;
    tests_run++;
    if (bad != 0 || !okall) begin
      tests_failed++;
      $display("FAIL b2b_order got=%0d mismatches want=0", bad);
    end
  endtask

  task automatic test_reset_abort();
    int n = 0, rb, bl, bw, len, r;
    logic [7:0] rv, d;
    bit ok, okall = 1;
    push0(1'b1, 4'd9, 8'h11, ok); okall &= ok;
    push0(1'b1, 4'd10, 8'h12, ok); okall &= ok;
    push0(1'b1, 4'd11, 8'h13, ok); okall &= ok;
    while (!(bdir && !bc) && n < 100) begin @(posedge clk); #1; n++; end
    tests_run++;
    if (!(bdir && !bc) || !okall) begin
      tests_failed++;
      $display("FAIL abort_reach_strobe got=%b%b want=10", bdir, bc);
    end
    rst_n = 1'b0;
    m_cache_v = 0;
    #1;
    tests_run++;
    if ({bdir, busy, req_ready, a8} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL abort_async got=%b want=0000", {bdir, busy, req_ready, a8});
    end
    rb = total_rises;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    tests_run++;
    if (total_rises != rb || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_discard got=%0d strobes busy=%b want=0 busy=0", total_rises - rb, busy);
    end
    bl = len_log.size();
    bw = wr_log.size();
    d = 8'($urandom_range(0, 31));
    model_exec(1'b1, 4'd9, d, len, rv, r);
    push0(1'b1, 4'd9, d, ok);
    wait_idle0(ok);
    tests_run++;
    if (len_log.size() != bl + 1 || len_log[bl] != len || rise_log[bl] != 2 || r != 2) begin
      tests_failed++;
      $display("FAIL abort_relatch got=%0d cycles want=%0d", (len_log.size() > bl) ? len_log[bl] : -1, len);
    end
    tests_run++;
    if (wr_log.size() != bw + 1 || wr_log[bw] !== {4'd9, d} || psg_regs[9] !== shadow[9]) begin
      tests_failed++;
      $display("FAIL abort_after_write got=%h want=%h", psg_regs[9], shadow[9]);
    end
  endtask

  logic [9:0] tr1[$];
  logic [3:0] latch1 = 4'd0;
  logic [7:0] r13_1 = 8'h00;
  int         env_restarts = 0;

  task automatic run1(input logic [3:0] a, input logic [7:0] d, output int len, output bit ok);
    bit seen = 0, prev_b = 0;
    int n = 0;
    len = 0;
    tr1.delete();
    req_valid1 = 1'b1; req_wr1 = 1'b1; req_addr1 = a; req_data1 = d;
    ok = req_ready1;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    while (n < 40 && !(seen && !a81)) begin
      if (a81) begin
        seen = 1;
        len++;
        tr1.push_back({bdir1, bc1, dout1});
        if (bdir1 && !prev_b) begin
          if (bc1) latch1 = dout1[3:0];
          else if (latch1 == 4'd13) begin r13_1 = dout1 & 8'h0F; env_restarts++; end
        end
      end
      prev_b = bdir1;
      @(posedge clk); #1;
      n++;
    end
    ok = ok && seen && !a81;
  endtask

  task automatic test_phase1_reg13();
    logic [9:0] exp[$];
    int len, bad = 0, e0 = env_restarts;
    bit ok;
    exp = '{{2'b01, 8'h0D}, {2'b11, 8'h0D}, {2'b00, 8'h0E}, {2'b10, 8'h0E}, {2'b00, 8'h00}};
    run1(4'd13, 8'h0E, len, ok);
    if (tr1.size() != exp.size()) bad++;
    else for (int i = 0; i < exp.size(); i++) if (tr1[i] !== exp[i]) bad++;
    tests_run++;
    if (len != 5 || bad != 0 || !ok) begin
      tests_failed++;
      $display("FAIL p1_reg13_trace got=%0d cycles %0d bad want=5 cycles 0 bad", len, bad);
    end
    tests_run++;
    if (env_restarts - e0 != 1 || r13_1 !== 8'h0E) begin
      tests_failed++;
      $display("FAIL p1_env_restart got=%0d r13=%h want=1 r13=0e", env_restarts - e0, r13_1);
    end
    exp = '{{2'b00, 8'h0E}, {2'b10, 8'h0E}, {2'b00, 8'h00}};
    bad = 0;
    run1(4'd13, 8'h0E, len, ok);
    if (tr1.size() != exp.size()) bad++;
    else for (int i = 0; i < exp.size(); i++) if (tr1[i] !== exp[i]) bad++;
    tests_run++;
    if (len != 3 || bad != 0 || !ok || env_restarts - e0 != 2) begin
      tests_failed++;
      $display("FAIL p1_reg13_cached got=%0d cycles %0d restarts want=3 cycles 2 restarts", len, env_restarts - e0);
    end
  endtask

  task automatic test_random();
    int bl = len_log.size(), br = rsp_log.size(), bb = rsp_bad, len, r, bad = 0;
    int exp_len[$];
    logic [7:0] exp_rsp[$];
    logic [7:0] rv, d;
    logic [3:0] a = 4'd0;
    bit wr, ok, okall = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) a = 4'($urandom_range(0, 15));
      wr = ($urandom_range(0, 2) != 0);
      d  = 8'($urandom);
      model_exec(wr, a, d, len, rv, r);
      exp_len.push_back(len);
      if (!wr) exp_rsp.push_back(rv);
      push0(wr, a, d, ok); okall &= ok;
    end
    wait_idle0(ok); okall &= ok;
    if (len_log.size() != bl + exp_len.size()) bad++;
    else for (int i = 0; i < exp_len.size(); i++) if (len_log[bl + i] != exp_len[i]) bad++;
    tests_run++;
    if (bad != 0 || !okall) begin
      tests_failed++;
      $display("FAIL rand_timing got=%0d mismatches want=0", bad);
    end
    bad = 0;
    if (rsp_log.size() != br + exp_rsp.size()) bad++;
    else for (int i = 0; i < exp_rsp.size(); i++) if (rsp_log[br + i] !== exp_rsp[i]) bad++;
    tests_run++;
    if (bad != 0 || rsp_bad != bb) begin
      tests_failed++;
      $display("FAIL rand_read_data got=%0d mismatches %0d bad pulses want=0", bad, rsp_bad - bb);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) if (psg_regs[i] !== shadow[i]) bad++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL rand_psg_regs got=%0d differing want=0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_reg7_write();
    test_cached_write();
    test_read();
    test_back_to_back();
    test_reset_abort();
    test_phase1_reg13();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
